// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FIFO read-side unpacker.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // A word must split into a whole number (>=1) of non-empty slices.
  function automatic bit ratio_ok(input int din_w, input int dout_w);
    if (dout_w <= 0 || din_w <= 0) return 1'b0;
    if (din_w < dout_w)            return 1'b0;
    return (din_w % dout_w) == 0;
  endfunction

  function automatic int cnt_bits(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_rd_unpack.sv
// FIFO read-side controller: pops wide words and streams them out as
// narrow slices, most-significant slice first, on a valid/ready interface.
module fifo_rd_unpack
  import fifo_pkg::*;
#(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 8
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic                     flag_empty,
  output logic                     r_en,
  input  logic [DATAIN_WIDTH-1:0]  data_read,
  output logic [DATAOUT_WIDTH-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic                     busy
);

  localparam int                 RATIO    = DATAIN_WIDTH / DATAOUT_WIDTH;
  localparam int                 CNT_BIT  = cnt_bits(RATIO);
  localparam logic [CNT_BIT-1:0] LAST_IDX = CNT_BIT'(RATIO - 1);

  if (!ratio_ok(DATAIN_WIDTH, DATAOUT_WIDTH)) begin : g_ratio_bad
    $error("fifo_rd_unpack: DATAIN_WIDTH must be a positive multiple of DATAOUT_WIDTH");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATAIN_WIDTH-1:0] r_shift;
  logic [CNT_BIT-1:0]      r_idx;
  logic                    w_send;
  logic                    w_last;
  logic                    w_xfer;
  logic                    w_pop;

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_idx == LAST_IDX);
  assign w_xfer = w_send && dout_ready;

  // Pop decision is combinational so the last-slice transfer and the next
  // pop share a cycle, leaving only the LOAD cycle as a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flag_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_state_nxt = SEND;
      end
      SEND: begin
        if (w_xfer && w_last) begin
          if (!flag_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == LOAD) begin
        r_shift <= data_read;
        r_idx   <= '0;
      end else if (w_xfer && !w_last) begin
        r_shift <= r_shift << DATAOUT_WIDTH;
        r_idx   <= r_idx + CNT_BIT'(1);
      end
    end
  end

  assign r_en       = w_pop;
  assign dout       = r_shift[DATAIN_WIDTH-1 -: DATAOUT_WIDTH];
  assign dout_valid = w_send;
  assign dout_last  = w_last;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Bench for fifo_rd_unpack: queue-based FIFO and slice model for a 16->8 build,
// plus a 32->8 build checked against literal expectations.
module tb_fifo_rd_unpack;

  typedef struct { logic [7:0] d; logic l; } exp_t;
  typedef struct { logic [7:0] d; logic l; int c; } ent_t;

  logic        clk;
  logic        r_rst;
  logic        flag_empty, r_en, dout_valid, dout_ready, dout_last, busy;
  logic [15:0] data_read;
  logic [7:0]  dout;

  logic        flag_empty4, r_en4, dout_valid4, dout_ready4, dout_last4, busy4;
  logic [31:0] data_read4;
  logic [7:0]  dout4;

  logic [15:0] q[$];
  logic [31:0] q4[$];
  exp_t        expq[$];
  ent_t        log_q[$];
  ent_t        log4[$];
  int          pop_cyc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int pops = 0;
  int pops4 = 0;
  int fall_cyc = -1;

  fifo_rd_unpack #(.DATAIN_WIDTH(16), .DATAOUT_WIDTH(8)) dut (
    .r_clk(clk), .r_rst(r_rst), .flag_empty(flag_empty), .r_en(r_en),
    .data_read(data_read), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy)
  );

  fifo_rd_unpack #(.DATAIN_WIDTH(32), .DATAOUT_WIDTH(8)) dut4 (
    .r_clk(clk), .r_rst(r_rst), .flag_empty(flag_empty4), .r_en(r_en4),
    .data_read(data_read4), .dout(dout4), .dout_valid(dout_valid4),
    .dout_ready(dout_ready4), .dout_last(dout_last4), .busy(busy4)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_t e;
    q.push_back(w);
    for (int k = 0; k < 2; k++) begin
      e.d = 8'(w >> ((1 - k) * 8));
      e.l = (k == 1);
      expq.push_back(e);
    end
  endtask

  task automatic wait_log(input int n, input int maxc);
    for (int i = 0; i < maxc && log_q.size() < n; i++) cyc();
    if (log_q.size() < n) chk("wait_log_timeout", log_q.size(), n);
  endtask

  // FIFO models: a pop requested during a cycle returns data after that edge.
  initial begin
    logic pend;
    flag_empty = 1'b1;
    data_read  = '0;
    forever begin
      @(negedge clk);
      pend = r_en && !r_rst;
      @(posedge clk);
      #1;
      if (pend && q.size() > 0) data_read = q.pop_front();
      flag_empty = (q.size() == 0);
    end
  end

  initial begin
    logic pend;
    flag_empty4 = 1'b1;
    data_read4  = '0;
    forever begin
      @(negedge clk);
      pend = r_en4 && !r_rst;
      @(posedge clk);
      #1;
      if (pend && q4.size() > 0) data_read4 = q4.pop_front();
      flag_empty4 = (q4.size() == 0);
    end
  end

  // Compare process for the 16->8 build, evaluated mid-cycle.
  initial begin
    logic       prev_v, prev_r, prev_rst, prev_l, prev_fe;
    logic [7:0] prev_d;
    exp_t       e;
    ent_t       en;
    prev_v = 0; prev_r = 0; prev_rst = 1; prev_l = 0; prev_d = 0; prev_fe = 1;
    forever begin
      @(negedge clk);
      if (flag_empty) chk("ren_while_empty", r_en, 1'b0);
      if (prev_fe && !flag_empty) fall_cyc = cyc_n;
      if (r_en && !r_rst) begin
        pops++;
        pop_cyc.push_back(cyc_n);
      end
      if (prev_v && !prev_r && !prev_rst) begin
        chk("stall_valid", dout_valid, 1'b1);
        chk("stall_dout", dout, prev_d);
        chk("stall_last", dout_last, prev_l);
      end
      if (dout_valid && dout_ready && !r_rst) begin
        if (expq.size() == 0) begin
          chk("unexpected_slice", dout, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("slice_data", dout, e.d);
          chk("slice_last", dout_last, e.l);
        end
        en.d = dout; en.l = dout_last; en.c = cyc_n;
        log_q.push_back(en);
      end
      prev_v = dout_valid; prev_r = dout_ready; prev_rst = r_rst;
      prev_d = dout; prev_l = dout_last; prev_fe = flag_empty;
    end
  end

  initial forever begin
    ent_t en;
    @(negedge clk);
    if (r_en4 && !r_rst) pops4++;
    if (dout_valid4 && dout_ready4 && !r_rst) begin
      en.d = dout4; en.l = dout_last4; en.c = cyc_n;
      log4.push_back(en);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, p0;
    r_rst = 1'b1;
    dout_ready = 1'b1;
    dout_ready4 = 1'b1;
    repeat (3) cyc();

    // Reset state
    chk("rst_ren", r_en, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_last", dout_last, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 1'b0);
    r_rst = 1'b0;
    cyc();

    // 1: single word
    b = log_q.size(); p0 = pops;
    push_word(16'hA55A);
    wait_log(b + 2, 20);
    repeat (2) cyc();
    chk("t1_s0", log_q[b].d, 8'hA5);
    chk("t1_l0", log_q[b].l, 1'b0);
    chk("t1_s1", log_q[b+1].d, 8'h5A);
    chk("t1_l1", log_q[b+1].l, 1'b1);
    chk("t1_pops", pops - p0, 1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_valid", dout_valid, 1'b0);

    // 2: back-to-back words
    b = log_q.size(); p0 = pop_cyc.size();
    push_word(16'h1234);
    push_word(16'h5678);
    wait_log(b + 4, 30);
    repeat (2) cyc();
    chk("t2_s0", log_q[b].d, 8'h12);
    chk("t2_s1", log_q[b+1].d, 8'h34);
    chk("t2_s2", log_q[b+2].d, 8'h56);
    chk("t2_s3", log_q[b+3].d, 8'h78);
    chk("t2_gap01", log_q[b+1].c - log_q[b].c, 1);
    chk("t2_gap12", log_q[b+2].c - log_q[b+1].c, 2);
    chk("t2_gap23", log_q[b+3].c - log_q[b+2].c, 1);
    chk("t2_pops", pop_cyc.size() - p0, 2);
    chk("t2_overlap_pop", pop_cyc[p0+1], log_q[b+1].c);

    // 3: backpressure on the first slice
    b = log_q.size(); p0 = pops;
    dout_ready = 1'b0;
    push_word(16'hBEEF);
    for (int i = 0; i < 20 && !dout_valid; i++) cyc();
    chk("t3_valid_seen", dout_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_dout", dout, 8'hBE);
      chk("t3_hold_last", dout_last, 1'b0);
      cyc();
    end
    dout_ready = 1'b1;
    wait_log(b + 2, 20);
    repeat (3) cyc();
    chk("t3_s0", log_q[b].d, 8'hBE);
    chk("t3_s1", log_q[b+1].d, 8'hEF);
    chk("t3_l1", log_q[b+1].l, 1'b1);
    chk("t3_pops", pops - p0, 1);

    // 4: long empty period, then one word
    for (int i = 0; i < 10; i++) begin
      chk("t4_ren_idle", r_en, 1'b0);
      cyc();
    end
    b = log_q.size();
    push_word(16'h00FF);
    wait_log(b + 2, 20);
    chk("t4_s0", log_q[b].d, 8'h00);
    chk("t4_s1", log_q[b+1].d, 8'hFF);
    chk("t4_latency", log_q[b].c - fall_cyc, 2);
    repeat (2) cyc();

    // 5: reset after the first slice of a word
    b = log_q.size();
    push_word(16'hC33C);
    wait_log(b + 1, 20);
    chk("t5_s0", log_q[b].d, 8'hC3);
    r_rst = 1'b1;
    dout_ready = 1'b0;
    expq.delete();
    q.delete();
    cyc();
    chk("t5_valid", dout_valid, 1'b0);
    chk("t5_ren", r_en, 1'b0);
    chk("t5_busy", busy, 1'b0);
    r_rst = 1'b0;
    dout_ready = 1'b1;
    cyc();
    b = log_q.size();
    push_word(16'h0102);
    wait_log(b + 2, 20);
    chk("t5_post_s0", log_q[b].d, 8'h01);
    chk("t5_post_s1", log_q[b+1].d, 8'h02);
    chk("t5_post_len", log_q.size() - b, 2);
    repeat (3) cyc();
    chk("pops_total", pops, 7);
    chk("model_drained", expq.size(), 0);

    // 6: 32->8 build
    q4.push_back(32'hDEADBEEF);
    for (int i = 0; i < 30 && log4.size() < 4; i++) cyc();
    repeat (3) cyc();
    chk("t6_len", log4.size(), 4);
    if (log4.size() >= 4) begin
      chk("t6_s0", log4[0].d, 8'hDE);
      chk("t6_s1", log4[1].d, 8'hAD);
      chk("t6_s2", log4[2].d, 8'hBE);
      chk("t6_s3", log4[3].d, 8'hEF);
      chk("t6_lasts", {log4[0].l, log4[1].l, log4[2].l, log4[3].l}, 4'b0001);
      chk("t6_gap", log4[3].c - log4[0].c, 3);
    end
    chk("t6_pops", pops4, 1);
    chk("t6_busy", busy4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
